// File: rtl/genius_pkg.sv
// genius_pkg: shared definitions for the parametrised memory game.
//   estado_t  : 4-bit state codes, also exported on db_estado
//   LFSR_TAPS : feedback mask for the 16-bit right-shifting Fibonacci LFSR
//   onehot()  : button index -> LED/button one-hot pattern
package genius_pkg;

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARA     = 4'h1,
        GERA        = 4'h2,
        MOSTRA      = 4'h3,
        INTERVALO   = 4'h4,
        ESPERA      = 4'h5,
        COMPARA     = 4'h6,
        PROXIMA     = 4'h7,
        FIM_GANHOU  = 4'hA,
        FIM_TIMEOUT = 4'hD,
        FIM_PERDEU  = 4'hE
    } estado_t;

    // Taps 16,14,13,11 expressed as stage positions 0,2,3,5 of a register
    // that shifts right and feeds the new bit into position 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Bits above num_botoes are masked so callers can truncate freely.
    function automatic logic [15:0] onehot(input logic [3:0] idx, input int num_botoes);
        logic [15:0] mask;
        mask = (num_botoes >= 16) ? 16'hFFFF : ((16'd1 << num_botoes) - 16'd1);
        return (16'd1 << idx) & mask;
    endfunction

endpackage

// File: rtl/genius_param_if.sv
// genius_param_if: game I/O bundle.
//   slave  (game core): in  jogar, botoes
//                       out leds, pronto, ganhou, perdeu, db_timeout,
//                           db_estado, db_rodada, db_jogada
//   master (board/bench): the mirror image
interface genius_param_if #(
    parameter int NUM_BOTOES  = 4,
    parameter int MAX_RODADAS = 16
);
    localparam int RW = $clog2(MAX_RODADAS);

    logic                  jogar;
    logic [NUM_BOTOES-1:0] botoes;
    logic [NUM_BOTOES-1:0] leds;
    logic                  pronto;
    logic                  ganhou;
    logic                  perdeu;
    logic                  db_timeout;
    logic [3:0]            db_estado;
    logic [RW-1:0]         db_rodada;
    logic [NUM_BOTOES-1:0] db_jogada;

    modport slave (
        input  jogar, botoes,
        output leds, pronto, ganhou, perdeu, db_timeout,
               db_estado, db_rodada, db_jogada
    );

    modport master (
        output jogar, botoes,
        input  leds, pronto, ganhou, perdeu, db_timeout,
               db_estado, db_rodada, db_jogada
    );
endinterface

// File: rtl/genius_lfsr.sv
// genius_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11).
//   clock : system clock
//   load  : synchronous reload of SEMENTE (driven from the game reset)
//   en    : advance one step
//   item  : low ITEM_W bits of the current state (value before the advance)
module genius_lfsr
    import genius_pkg::*;
#(
    parameter logic [15:0] SEMENTE = 16'hACE1,
    parameter int          ITEM_W  = 2
) (
    input  logic              clock,
    input  logic              load,
    input  logic              en,
    output logic [ITEM_W-1:0] item
);
    logic [15:0] st;

    always_ff @(posedge clock) begin
        if (load)
            st <= SEMENTE;
        else if (en)
            st <= {^(st & LFSR_TAPS), st[15:1]};
    end

    assign item = st[ITEM_W-1:0];
endmodule

// File: rtl/genius_param.sv
// genius_param: parametrised memory game core.
//   clock, reset (synchronous, active-low)
//   bus (genius_param_if.slave): jogar/botoes in; leds, result flags and
//   debug state/round/last-press out.
// Each round appends one LFSR item to the sequence, replays the whole
// sequence on the LEDs, then checks the player's presses one by one.
// Optional feature macro GENIUS_TIMEOUT_EN: per-press timeout. Without it
// ESPERA waits forever and db_timeout is tied low.
module genius_param
    import genius_pkg::*;
#(
    parameter int          NUM_BOTOES     = 4,
    parameter int          MAX_RODADAS    = 16,
    parameter int          SHOW_CICLOS    = 1000,
    parameter int          GAP_CICLOS     = 500,
    parameter int          TIMEOUT_CICLOS = 5000,
    parameter logic [15:0] SEMENTE        = 16'hACE1
) (
    input  logic           clock,
    input  logic           reset,
    genius_param_if.slave  bus
);
    localparam int IW   = $clog2(NUM_BOTOES);
    localparam int RW   = $clog2(MAX_RODADAS);
    localparam int CMAX = (SHOW_CICLOS > GAP_CICLOS) ? SHOW_CICLOS : GAP_CICLOS;
    localparam int CW   = $clog2(CMAX + 1);

    if (NUM_BOTOES < 2 || NUM_BOTOES > 16 || (NUM_BOTOES & (NUM_BOTOES - 1)) != 0 ||
        MAX_RODADAS < 2 || MAX_RODADAS > 64 || SHOW_CICLOS < 1 || GAP_CICLOS < 1 ||
        TIMEOUT_CICLOS < 2 || SEMENTE == 16'h0) begin : g_bad_param
        $error("genius_param: parameter out of range");
    end

    estado_t               estado, estado_n;
    logic [RW-1:0]         rodada, rodada_n;
    logic [RW-1:0]         idx, idx_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [NUM_BOTOES-1:0] jogada, jogada_n;
    logic [NUM_BOTOES-1:0] botoes_ant;
    logic [IW-1:0]         mem [MAX_RODADAS];
    logic [IW-1:0]         item;
    logic [NUM_BOTOES-1:0] esperado;
    logic                  press;
    logic                  idx_fim;

`ifdef GENIUS_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CICLOS);
    logic [TW-1:0] timer, timer_n;
`endif

    genius_lfsr #(.SEMENTE(SEMENTE), .ITEM_W(IW)) u_lfsr (
        .clock (clock),
        .load  (~reset),
        .en    (estado == GERA),
        .item  (item)
    );

    // Rising edge of "any button": holding or adding buttons is not a new press.
    assign press    = (bus.botoes != '0) && (botoes_ant == '0);
    assign idx_fim  = (idx == rodada);
    assign esperado = NUM_BOTOES'(onehot(4'(mem[idx]), NUM_BOTOES));

    always_comb begin
        estado_n = estado;
        rodada_n = rodada;
        idx_n    = idx;
        cnt_n    = cnt;
        jogada_n = jogada;
`ifdef GENIUS_TIMEOUT_EN
        timer_n  = timer;
`endif
        case (estado)
            INICIAL: if (bus.jogar) estado_n = PREPARA;
            PREPARA: begin
                rodada_n = '0;
                idx_n    = '0;
                jogada_n = '0;
                estado_n = GERA;
            end
            GERA: begin
                idx_n    = '0;
                cnt_n    = '0;
                estado_n = MOSTRA;
            end
            MOSTRA: begin
                if (cnt == CW'(SHOW_CICLOS - 1)) begin
                    cnt_n    = '0;
                    estado_n = INTERVALO;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            INTERVALO: begin
                if (cnt == CW'(GAP_CICLOS - 1)) begin
                    cnt_n = '0;
                    if (idx_fim) begin
                        idx_n    = '0;
`ifdef GENIUS_TIMEOUT_EN
                        timer_n  = '0;
`endif
                        estado_n = ESPERA;
                    end else begin
                        idx_n    = idx + 1'b1;
                        estado_n = MOSTRA;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ESPERA: begin
`ifdef GENIUS_TIMEOUT_EN
                timer_n = timer + 1'b1;
`endif
                // A press on the timeout cycle still counts as a press.
                if (press) begin
                    jogada_n = bus.botoes;
                    estado_n = COMPARA;
                end
`ifdef GENIUS_TIMEOUT_EN
                else if (timer == TW'(TIMEOUT_CICLOS - 1)) begin
                    estado_n = FIM_TIMEOUT;
                end
`endif
            end
            COMPARA: begin
                if (jogada != esperado) begin
                    estado_n = FIM_PERDEU;
                end else if (!idx_fim) begin
                    idx_n    = idx + 1'b1;
`ifdef GENIUS_TIMEOUT_EN
                    timer_n  = '0;
`endif
                    estado_n = ESPERA;
                end else if (rodada == RW'(MAX_RODADAS - 1)) begin
                    estado_n = FIM_GANHOU;
                end else begin
                    estado_n = PROXIMA;
                end
            end
            PROXIMA: begin
                rodada_n = rodada + 1'b1;
                estado_n = GERA;
            end
            FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (bus.jogar) estado_n = PREPARA;
            default: estado_n = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            estado     <= INICIAL;
            rodada     <= '0;
            idx        <= '0;
            cnt        <= '0;
            jogada     <= '0;
            botoes_ant <= '0;
`ifdef GENIUS_TIMEOUT_EN
            timer      <= '0;
`endif
        end else begin
            estado     <= estado_n;
            rodada     <= rodada_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            jogada     <= jogada_n;
            botoes_ant <= bus.botoes;
`ifdef GENIUS_TIMEOUT_EN
            timer      <= timer_n;
`endif
        end
    end

    // Sequence memory has no reset: entry r is always written in GERA of
    // round r before any replay or compare reads it.
    always_ff @(posedge clock) begin
        if (reset && estado == GERA)
            mem[rodada] <= item;
    end

    assign bus.leds      = (estado == MOSTRA) ? esperado :
                           (estado == ESPERA) ? bus.botoes : '0;
    assign bus.pronto    = estado inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
    assign bus.ganhou    = (estado == FIM_GANHOU);
    assign bus.perdeu    = (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
`ifdef GENIUS_TIMEOUT_EN
    assign bus.db_timeout = (estado == FIM_TIMEOUT);
`else
    assign bus.db_timeout = 1'b0;
`endif
    assign bus.db_estado = estado;
    assign bus.db_rodada = rodada;
    assign bus.db_jogada = jogada;
endmodule

// File: tb/tb_genius_param.sv
`timescale 1ns/1ps
module tb_genius_param;
    localparam int          NB   = 4;
    localparam int          MR   = 3;
    localparam int          SHOW = 4;
    localparam int          GAP  = 2;
    localparam int          TO   = 20;
    localparam logic [15:0] SEED = 16'hACE1;
`ifdef GENIUS_TIMEOUT_EN
    localparam int          HOLD = 12;
`else
    localparam int          HOLD = 30;
`endif

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    genius_param_if #(.NUM_BOTOES(NB), .MAX_RODADAS(MR)) bus ();

    genius_param #(
        .NUM_BOTOES(NB), .MAX_RODADAS(MR), .SHOW_CICLOS(SHOW),
        .GAP_CICLOS(GAP), .TIMEOUT_CICLOS(TO), .SEMENTE(SEED)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] lfsr_m;
    logic [1:0]  seq [$];
    logic [3:0]  exp_q [$];

    task automatic step();
        @(negedge clock);
    endtask

    function automatic logic [3:0] oh(input logic [1:0] v);
        logic [3:0] one;
        one = 4'b0001;
        return one << v;
    endfunction

    // Reference generator: append this round's item and queue the full replay.
    task automatic gen_round();
        seq.push_back(lfsr_m[1:0]);
        lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
        foreach (seq[i]) exp_q.push_back(oh(seq[i]));
    endtask

    task automatic start_game();
        bus.jogar = 1'b1;
        step();
        bus.jogar = 1'b0;
        n_cmp++;
        if (bus.db_estado !== 4'h1) begin
            n_err++; $display("FAIL start_prepara: state=%h required 1", bus.db_estado);
        end
        seq.delete();
        exp_q.delete();
    endtask

    // Drains the scoreboard against the LED replay: item value, lit length, gap length.
    task automatic replay(input int n);
        logic [3:0] e;
        int k, lit, dark;
        for (int i = 0; i < n; i++) begin
            k = 0;
            while (bus.db_estado !== 4'h3 && k < 100) begin step(); k++; end
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.leds !== e) begin
                n_err++; $display("FAIL replay_item[%0d]: leds=%b required %b", i, bus.leds, e);
            end
            lit = 0;
            while (bus.db_estado === 4'h3 && bus.leds === e && lit < 100) begin step(); lit++; end
            n_cmp++;
            if (lit != SHOW) begin
                n_err++; $display("FAIL replay_show[%0d]: lit=%0d required %0d", i, lit, SHOW);
            end
            dark = 0;
            while (bus.db_estado === 4'h4 && bus.leds === 4'b0 && dark < 100) begin step(); dark++; end
            n_cmp++;
            if (dark != GAP) begin
                n_err++; $display("FAIL replay_gap[%0d]: dark=%0d required %0d", i, dark, GAP);
            end
        end
        n_cmp++;
        if (bus.db_estado !== 4'h5) begin
            n_err++; $display("FAIL replay_end: state=%h required 5", bus.db_estado);
        end
    endtask

    // Hold 3 cycles; intermediate presses also release for 3 cycles.
    task automatic press(input logic [3:0] v, input bit last);
        bus.botoes = v;
        repeat (3) step();
        bus.botoes = '0;
        if (!last) repeat (3) step();
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.jogar = 1'b1; bus.botoes = '0;
        repeat (2) step();
        n_cmp++;
        if (bus.db_estado !== 4'h0) begin
            n_err++; $display("FAIL reset_state: state=%h required 0", bus.db_estado);
        end
        n_cmp++;
        if ({bus.leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout,
             bus.db_rodada, bus.db_jogada} !== '0) begin
            n_err++; $display("FAIL reset_outputs: leds=%b pronto=%b ganhou=%b perdeu=%b rodada=%0d jogada=%b required all 0",
                              bus.leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_rodada, bus.db_jogada);
        end
        reset = 1'b1; bus.jogar = 1'b0; lfsr_m = SEED;
        step();
        n_cmp++;
        if (bus.db_estado !== 4'h0) begin
            n_err++; $display("FAIL idle_no_jogar: state=%h required 0", bus.db_estado);
        end
        start_game();
        step();
        n_cmp++;
        if (bus.db_estado !== 4'h2) begin
            n_err++; $display("FAIL gera_state: state=%h required 2", bus.db_estado);
        end
        gen_round();
        step();
        n_cmp++;
        if (bus.db_estado !== 4'h3 || bus.leds !== 4'b0010) begin
            n_err++; $display("FAIL first_item: state=%h leds=%b required 3/0010", bus.db_estado, bus.leds);
        end
        replay(1);
    endtask

    task automatic test_win();
        press(oh(seq[0]), 1'b1);
        n_cmp++;
        if (bus.db_rodada !== 2'd1) begin
            n_err++; $display("FAIL round_advance: rodada=%0d required 1", bus.db_rodada);
        end
        gen_round(); replay(2);
        press(oh(seq[0]), 1'b0); press(oh(seq[1]), 1'b1);
        gen_round(); replay(3);
        press(oh(seq[0]), 1'b0); press(oh(seq[1]), 1'b0); press(oh(seq[2]), 1'b1);
        repeat (4) step();
        n_cmp++;
        if (bus.db_estado !== 4'hA || bus.ganhou !== 1'b1 || bus.pronto !== 1'b1 ||
            bus.perdeu !== 1'b0 || bus.db_rodada !== 2'd2) begin
            n_err++; $display("FAIL win: state=%h ganhou=%b pronto=%b perdeu=%b rodada=%0d required A/1/1/0/2",
                              bus.db_estado, bus.ganhou, bus.pronto, bus.perdeu, bus.db_rodada);
        end
    endtask

    task automatic test_wrong_press();
        logic [3:0] w;
        start_game(); gen_round(); replay(1);
        press(oh(seq[0]), 1'b1);
        gen_round(); replay(2);
        bus.jogar = 1'b1; step(); step(); bus.jogar = 1'b0;
        n_cmp++;
        if (bus.db_estado !== 4'h5) begin
            n_err++; $display("FAIL jogar_ignored: state=%h required 5", bus.db_estado);
        end
        w = (oh(seq[0]) == 4'b1000) ? 4'b0001 : 4'b1000;
        press(w, 1'b1);
        n_cmp++;
        if (bus.db_estado !== 4'hE || bus.perdeu !== 1'b1 || bus.ganhou !== 1'b0 ||
            bus.pronto !== 1'b1 || bus.db_timeout !== 1'b0 || bus.db_jogada !== w) begin
            n_err++; $display("FAIL wrong_press: state=%h perdeu=%b ganhou=%b jogada=%b required E/1/0/%b",
                              bus.db_estado, bus.perdeu, bus.ganhou, bus.db_jogada, w);
        end
    endtask

    task automatic test_hold_multi();
        int bad;
        start_game(); gen_round(); replay(1);
        press(oh(seq[0]), 1'b1);
        gen_round(); replay(2);
        bus.botoes = oh(seq[0]);
        step(); step();
        n_cmp++;
        if (bus.db_estado !== 4'h5 || bus.db_jogada !== oh(seq[0])) begin
            n_err++; $display("FAIL hold_match: state=%h jogada=%b required 5/%b", bus.db_estado, bus.db_jogada, oh(seq[0]));
        end
        bad = 0;
        repeat (HOLD) begin
            step();
            if (bus.db_estado !== 4'h5 || bus.leds !== bus.botoes) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL hold_no_event: %0d bad cycles required 0 (state=%h)", bad, bus.db_estado);
        end
        bus.botoes = '0;
        repeat (3) step();
        bus.botoes = 4'b0011;
        step(); step();
        bus.botoes = '0;
        n_cmp++;
        if (bus.db_estado !== 4'hE || bus.perdeu !== 1'b1 || bus.db_jogada !== 4'b0011) begin
            n_err++; $display("FAIL multi_press: state=%h perdeu=%b jogada=%b required E/1/0011",
                              bus.db_estado, bus.perdeu, bus.db_jogada);
        end
    endtask

    task automatic test_timeout();
        start_game(); gen_round(); replay(1);
`ifdef GENIUS_TIMEOUT_EN
        repeat (TO - 1) step();
        n_cmp++;
        if (bus.db_estado !== 4'h5) begin
            n_err++; $display("FAIL timeout_early: state=%h required 5", bus.db_estado);
        end
        step();
        n_cmp++;
        if (bus.db_estado !== 4'hD || bus.perdeu !== 1'b1 || bus.db_timeout !== 1'b1 ||
            bus.pronto !== 1'b1 || bus.ganhou !== 1'b0) begin
            n_err++; $display("FAIL timeout: state=%h perdeu=%b db_timeout=%b pronto=%b required D/1/1/1",
                              bus.db_estado, bus.perdeu, bus.db_timeout, bus.pronto);
        end
`else
        repeat (100) step();
        n_cmp++;
        if (bus.db_estado !== 4'h5 || bus.db_timeout !== 1'b0) begin
            n_err++; $display("FAIL no_timeout: state=%h db_timeout=%b required 5/0", bus.db_estado, bus.db_timeout);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int k;
`ifdef GENIUS_TIMEOUT_EN
        start_game(); gen_round(); replay(1);
`endif
        press(oh(seq[0]), 1'b1);
        gen_round();
        k = 0;
        while (bus.db_estado !== 4'h3 && k < 20) begin step(); k++; end
        step();
        n_cmp++;
        if (bus.db_estado !== 4'h3 || bus.db_rodada !== 2'd1) begin
            n_err++; $display("FAIL mid_mostra: state=%h rodada=%0d required 3/1", bus.db_estado, bus.db_rodada);
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if ({bus.db_estado, bus.leds, bus.pronto, bus.ganhou, bus.perdeu, bus.db_timeout,
             bus.db_rodada, bus.db_jogada} !== '0) begin
            n_err++; $display("FAIL reset_mid: state=%h leds=%b rodada=%0d jogada=%b required all 0",
                              bus.db_estado, bus.leds, bus.db_rodada, bus.db_jogada);
        end
        reset = 1'b1; lfsr_m = SEED;
        start_game(); gen_round();
        step(); step();
        n_cmp++;
        if (bus.db_estado !== 4'h3 || bus.leds !== 4'b0010) begin
            n_err++; $display("FAIL reseed_item: state=%h leds=%b required 3/0010", bus.db_estado, bus.leds);
        end
        replay(1);
    endtask

    initial begin
        bus.jogar  = 1'b0;
        bus.botoes = '0;
        test_reset();
        test_win();
        test_wrong_press();
        test_hold_multi();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end
endmodule
